alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter OP_MAX, default 9, is the highest legal ALU opcode (1=add 2=sub 3=mul 4=shr 5=shl 6=and 7=or 8=nor 9=slt).
REQ-002 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 REQ0  input  1  requester 0 request, level.
REQ-005 A0, B0  input  32 each  requester 0 operands.
REQ-006 OPRN0  input  6  requester 0 opcode.
REQ-007 ACK0  output  1  requester 0 accept pulse.
REQ-008 REQ1, A1, B1, OPRN1, ACK1 SHALL be identical in width and meaning for requester 1.
REQ-009 ALU_A, ALU_B  output  32 each  operands driven to the shared ALU.
REQ-010 ALU_OPRN  output  6  opcode driven to the shared ALU.
REQ-011 ALU_Y  input  32  combinational ALU result.
REQ-012 RESULT  output  32  captured result.
REQ-013 RESULT_ZERO  output  1  captured result equals zero.
REQ-014 RESULT_ID  output  1  requester that owns RESULT.
REQ-015 DONE  output  1  result-valid pulse.
REQ-016 ERR  output  1  illegal-opcode flag, valid with DONE.
REQ-017 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and RESP; IDLE->ISSUE on any sampled request; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 REQ0/REQ1 SHALL be sampled only in IDLE; requests in ISSUE or RESP are ignored, not queued.
REQ-020 Arbitration SHALL be round-robin via a LAST_GNT register: a single request is granted outright; when both request, the requester not equal to LAST_GNT wins; LAST_GNT updates on each grant.
REQ-021 On the grant edge (E0), operands, opcode and grant id SHALL be latched, the FSM enters ISSUE and the granted ACKn is high for exactly that one ISSUE cycle.
REQ-022 In ISSUE, ALU_A/ALU_B/ALU_OPRN SHALL present the latched values; in IDLE and RESP they SHALL be 0.
REQ-023 At edge E1 (end of ISSUE), RESULT SHALL capture ALU_Y, RESULT_ZERO SHALL capture (ALU_Y == 0) and RESULT_ID SHALL capture the grant id; DONE is high for the single RESP cycle.
REQ-024 Latency SHALL be: ACK one cycle after the grant edge, DONE two cycles after it; the next grant occurs no earlier than the third edge after E0.
REQ-025 An opcode of 0 or greater than OP_MAX SHALL still be granted and ACKed, but ALU_OPRN stays 0, RESULT=0, RESULT_ZERO=0 and ERR=1 during RESP.
REQ-026 ERR SHALL be 0 for legal opcodes and SHALL be low whenever DONE is low.
REQ-027 RESULT, RESULT_ZERO and RESULT_ID SHALL hold their values until the next capture.
REQ-028 A requester SHALL drop REQ within two cycles after ACK; a REQ still high when the FSM is back in IDLE is treated as a new request.

Reset
REQ-029 While RST=0, the state SHALL be IDLE, LAST_GNT=1 (so requester 0 wins the first tie), and every output (ACKn, ALU_*, RESULT, RESULT_ZERO, RESULT_ID, DONE, ERR, BUSY) SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight operation, with no DONE generated; the first request after release is served normally.

Verification
REQ-031 R0: A=5, B=7, OPRN=1 -> ACK0 at E0+1, DONE at E0+2 with RESULT=12, RESULT_ID=0, RESULT_ZERO=0, ERR=0.
REQ-032 R1: A=100, B=7, OPRN=2 -> RESULT=93, RESULT_ID=1; then A=5, B=5, OPRN=2 -> RESULT=0, RESULT_ZERO=1.
REQ-033 After reset, both held high (R0: 5*7 OPRN=3; R1: 5<7 OPRN=9) -> grant order R0,R1,R0,R1 with results 35,1,35,1; DONE spacing of 3 cycles.
REQ-034 OPRN=0, then OPRN=10 -> each is ACKed, ALU_OPRN=0 throughout, DONE with ERR=1 and RESULT=0.
REQ-035 RST pulled low during ISSUE -> all outputs 0 immediately, no DONE; after release, R0 add 5+7 -> RESULT=12.
REQ-036 R0 shl (A=5, B=1, OPRN=5) -> RESULT=10; shr (A=5, B=1, OPRN=4) -> RESULT=2; BUSY high across ISSUE and RESP only.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lets two requesters share one
// combinational ALU. Each accepted request takes three cycles:
// grant (IDLE -> ISSUE), issue to the ALU (ISSUE -> RESP), and result
// presentation (RESP -> IDLE). Opcodes outside 1..OP_MAX are accepted and
// acknowledged, but they report ERR and a zero result.
module alu_arbiter #(
   parameter int unsigned OP_MAX = 9
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0,
   input  logic [31:0] A0,
   input  logic [31:0] B0,
   input  logic [5:0]  OPRN0,
   output logic        ACK0,
   input  logic        REQ1,
   input  logic [31:0] A1,
   input  logic [31:0] B1,
   input  logic [5:0]  OPRN1,
   output logic        ACK1,
   output logic [31:0] ALU_A,
   output logic [31:0] ALU_B,
   output logic [5:0]  ALU_OPRN,
   input  logic [31:0] ALU_Y,
   output logic [31:0] RESULT,
   output logic        RESULT_ZERO,
   output logic        RESULT_ID,
   output logic        DONE,
   output logic        ERR,
   output logic        BUSY
);

   localparam logic [5:0] OP_MAX_L = 6'(OP_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   state_t      state;
   logic        last_gnt;
   logic        gnt_id;
   logic        lat_bad;

   logic        any_req;
   logic        nxt_gnt;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [5:0]  sel_op;
   logic        sel_bad;

   // Pick the winner among the current requests and select its operands
   always_comb begin
      any_req = REQ0 | REQ1;
      nxt_gnt = 1'b0;
      if (REQ0 && REQ1) begin
         nxt_gnt = ~last_gnt;
      end else if (REQ1) begin
         nxt_gnt = 1'b1;
      end
      sel_a   = nxt_gnt ? A1 : A0;
      sel_b   = nxt_gnt ? B1 : B0;
      sel_op  = nxt_gnt ? OPRN1 : OPRN0;
      sel_bad = (sel_op == 6'd0) || (sel_op > OP_MAX_L);
   end

   // Three-state sequencer; every output is registered
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         last_gnt    <= 1'b1;
         gnt_id      <= 1'b0;
         lat_bad     <= 1'b0;
         ACK0        <= 1'b0;
         ACK1        <= 1'b0;
         ALU_A       <= '0;
         ALU_B       <= '0;
         ALU_OPRN    <= '0;
         RESULT      <= '0;
         RESULT_ZERO <= 1'b0;
         RESULT_ID   <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= ISSUE;
                  gnt_id   <= nxt_gnt;
                  last_gnt <= nxt_gnt;
                  lat_bad  <= sel_bad;
                  ACK0     <= ~nxt_gnt;
                  ACK1     <= nxt_gnt;
                  // The ALU output registers double as the operand latch
                  ALU_A    <= sel_a;
                  ALU_B    <= sel_b;
                  ALU_OPRN <= sel_bad ? 6'd0 : sel_op;
                  BUSY     <= 1'b1;
               end
            end
            ISSUE: begin
               state       <= RESP;
               ACK0        <= 1'b0;
               ACK1        <= 1'b0;
               ALU_A       <= '0;
               ALU_B       <= '0;
               ALU_OPRN    <= '0;
               RESULT      <= lat_bad ? 32'd0 : ALU_Y;
               RESULT_ZERO <= ~lat_bad & (ALU_Y == 32'd0);
               RESULT_ID   <= gnt_id;
               DONE        <= 1'b1;
               ERR         <= lat_bad;
            end
            RESP: begin
               state <= IDLE;
               DONE  <= 1'b0;
               ERR   <= 1'b0;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
